// File: rtl/acc_core_pkg.sv
// acc_core_pkg -- shared definitions for the multi-cycle accumulator core.
//   state_t        : core sequencing states
//   OP_*           : 4-bit opcodes (inst[8]=0 encoding)
//   field limits   : bit positions of the instruction fields in the 9-bit word
package acc_core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEM,
      HALT
   } state_t;

   localparam logic [3:0] OP_LDR  = 4'h0;
   localparam logic [3:0] OP_STR  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_LDI  = 4'h9;
   localparam logic [3:0] OP_LD   = 4'hA;
   localparam logic [3:0] OP_ST   = 4'hB;
   localparam logic [3:0] OP_CLRO = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Instruction word: [8] branch flag, [7:4] opcode, [3:0] index/immediate,
   // [7:0] branch target when [8] is set.
   localparam int BZ_BIT     = 8;
   localparam int BZ_TGT_MSB = 7;
   localparam int OP_MSB     = 7;
   localparam int OP_LSB     = 4;
   localparam int IDX_MSB    = 3;
   localparam int IDX_LSB    = 0;

endpackage

// File: rtl/acc_alu.sv
// acc_alu -- combinational accumulator ALU.
//   op         : opcode (acc_core_pkg::OP_*)
//   acc        : current accumulator
//   operand    : register-file operand R[i]
//   ovf_in     : current carry/borrow flag
//   shamt      : instruction index field, used as shift amount / immediate
//   result     : new accumulator value (meaningful when writes_acc=1)
//   ovf_out    : new flag value (equals ovf_in except for ADD/SUB/CLRO)
//   writes_acc : opcode updates the accumulator
module acc_alu
   import acc_core_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] acc,
   input  logic [DW-1:0] operand,
   input  logic          ovf_in,
   input  logic [3:0]    shamt,
   output logic [DW-1:0] result,
   output logic          ovf_out,
   output logic          writes_acc
);

   logic [DW:0] wide;

   // NOTE: every output of a combinational block gets a default before the
   // case, so no path through it can leave a value unassigned and infer a latch.
   always_comb begin
      result     = acc;
      ovf_out    = ovf_in;
      writes_acc = 1'b1;
      wide       = '0;
      case (op)
         OP_LDR: result = operand;
         OP_ADD: begin
            wide    = {1'b0, acc} + {1'b0, operand} + {{DW{1'b0}}, ovf_in};
            result  = wide[DW-1:0];
            ovf_out = wide[DW];
         end
         OP_SUB: begin
            // Top bit of the extended difference is the borrow.
            wide    = {1'b0, acc} - {1'b0, operand} - {{DW{1'b0}}, ovf_in};
            result  = wide[DW-1:0];
            ovf_out = wide[DW];
         end
         OP_AND: result = acc & operand;
         OP_OR:  result = acc | operand;
         OP_XOR: result = acc ^ operand;
         // Shifts by DW or more naturally yield zero.
         OP_SHL: result = acc << shamt;
         OP_SHR: result = acc >> shamt;
         OP_LDI: result = DW'(shamt);
         OP_CLRO: begin
            ovf_out    = 1'b0;
            writes_acc = 1'b0;
         end
         default: writes_acc = 1'b0;   // STR, LD, ST, NOPs, HALT
      endcase
   end

endmodule

// File: rtl/acc_core_mc.sv
// acc_core_mc -- parametrised multi-cycle accumulator core.
//   CLK, RESET_N       : clock (rising edge), asynchronous active-low reset
//   start              : run pulse, honoured in IDLE/HALT only
//   halt, busy         : status (HALT state / FETCH-EXEC-MEM)
//   imem_addr/data     : instruction ROM port, combinational read at pc
//   mem_req/we/addr/wdata/rdata/ack : data memory handshake, any wait states
//   acc_dbg, ovf_dbg   : accumulator and carry/borrow flag
//   cycle_ct, instr_ct : busy cycles / retired instructions, saturating
module acc_core_mc
   import acc_core_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NREG = 16,
   parameter int PCW  = 8,
   parameter int IW   = 9,
   parameter int CW   = 32
) (
   input  logic           CLK,
   input  logic           RESET_N,
   input  logic           start,
   output logic           halt,
   output logic           busy,
   output logic [PCW-1:0] imem_addr,
   input  logic [IW-1:0]  imem_data,
   output logic           mem_req,
   output logic           mem_we,
   output logic [DW-1:0]  mem_addr,
   output logic [DW-1:0]  mem_wdata,
   input  logic [DW-1:0]  mem_rdata,
   input  logic           mem_ack,
   output logic [DW-1:0]  acc_dbg,
   output logic           ovf_dbg,
   output logic [CW-1:0]  cycle_ct,
   output logic [CW-1:0]  instr_ct
);

   localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

   state_t         state, state_n;
   logic [PCW-1:0] pc;
   logic [IW-1:0]  ir;
   logic [DW-1:0]  acc;
   logic           ovf;
   logic [DW-1:0]  regs [NREG];

   logic           is_bz, is_mem, idx_ok, retire;
   logic [3:0]     op, idx;
   logic [DW-1:0]  reg_rd, alu_res;
   logic           alu_ovf, alu_wr;

   assign is_bz  = ir[BZ_BIT];
   assign op     = ir[OP_MSB:OP_LSB];
   assign idx    = ir[IDX_MSB:IDX_LSB];
   assign is_mem = !is_bz && (op == OP_LD || op == OP_ST);
   // Indices past the populated file read as zero and drop writes.
   assign idx_ok = 32'(idx) < NREG;
   assign reg_rd = idx_ok ? regs[idx[RIW-1:0]] : '0;

   assign imem_addr = pc;
   assign acc_dbg   = acc;
   assign ovf_dbg   = ovf;

   acc_alu #(.DW(DW)) u_alu (
      .op         (op),
      .acc        (acc),
      .operand    (reg_rd),
      .ovf_in     (ovf),
      .shamt      (idx),
      .result     (alu_res),
      .ovf_out    (alu_ovf),
      .writes_acc (alu_wr)
   );

   // NOTE: state is held in flops written with non-blocking assignments only,
   // so every sequential block samples pre-edge values regardless of order.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n   = state;
      halt      = 1'b0;
      busy      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      unique case (state)
         IDLE: if (start) state_n = FETCH;
         FETCH: begin
            busy    = 1'b1;
            state_n = EXEC;
         end
         EXEC: begin
            busy   = 1'b1;
            retire = !is_mem;
            if (is_bz)                state_n = FETCH;
            else if (is_mem)          state_n = MEM;
            else if (op == OP_HALT)   state_n = HALT;
            else                      state_n = FETCH;
         end
         MEM: begin
            // Address and data come from R[i]/acc, which cannot change while
            // the request is outstanding, so they stay stable until ack.
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = (op == OP_ST);
            mem_addr  = reg_rd;
            mem_wdata = acc;
            retire    = mem_ack;
            if (mem_ack) state_n = FETCH;
         end
         HALT: begin
            halt = 1'b1;
            if (start) state_n = FETCH;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc       <= '0;
         ir       <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
         cycle_ct <= '0;
         instr_ct <= '0;
         // NOTE: the register file must come out of reset cleared, so it is
         // built from resettable flops rather than an unreset RAM array.
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
      end else begin
         if (busy && ~&cycle_ct)   cycle_ct <= cycle_ct + 1'b1;
         if (retire && ~&instr_ct) instr_ct <= instr_ct + 1'b1;
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  pc       <= '0;
                  acc      <= '0;
                  ovf      <= 1'b0;
                  cycle_ct <= '0;
                  instr_ct <= '0;
               end
            end
            FETCH: ir <= imem_data;
            EXEC: begin
               if (is_bz) begin
                  pc <= (acc == '0) ? PCW'(ir[BZ_TGT_MSB:0]) : pc + 1'b1;
               end else if (!is_mem && op != OP_HALT) begin
                  if (alu_wr) acc <= alu_res;
                  ovf <= alu_ovf;
                  if (op == OP_STR && idx_ok) regs[idx[RIW-1:0]] <= acc;
                  pc <= pc + 1'b1;
               end
            end
            MEM: begin
               if (mem_ack) begin
                  if (op == OP_LD) acc <= mem_rdata;
                  pc <= pc + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
